// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - per-retire circular trace capture with pc trigger and oldest-first readout
// Optional feature macro: TRACE_TIMESTAMP_EN (per-entry cycle timestamp; rd_timestamp is 0 when undefined)
module cpu_trace_buffer #(
  parameter int PC_WIDTH       = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEPTH          = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_valid,
  input  logic [PC_WIDTH-1:0]       trace_pc,
  input  logic                      trace_reg_we,
  input  logic [REG_ADDR_WIDTH-1:0] trace_reg_addr,
  input  logic [DATA_WIDTH-1:0]     trace_reg_data,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [PC_WIDTH-1:0]       trigger_pc,
  input  logic [CNT_WIDTH-1:0]      post_count,
  output logic                      armed,
  output logic                      triggered,
  output logic                      done,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [PC_WIDTH-1:0]       rd_pc,
  output logic                      rd_reg_we,
  output logic [REG_ADDR_WIDTH-1:0] rd_reg_addr,
  output logic [DATA_WIDTH-1:0]     rd_reg_data,
  output logic [CNT_WIDTH-1:0]      rd_timestamp,
  output logic                      rd_last
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] MAX_POST = CNT_WIDTH'(DEPTH - 1);
  localparam logic [PTR_W:0]       FULL     = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_DONE, S_READOUT} state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]             count_q, count_d;
  logic [CNT_WIDTH-1:0]       post_rem_q, post_rem_d;
  logic [CNT_WIDTH-1:0]       post_cfg_q, post_cfg_d;
  logic [PC_WIDTH-1:0]        trig_pc_q, trig_pc_d;
  logic                       triggered_q, triggered_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             rd_idx_q, rd_idx_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [PC_WIDTH-1:0]        rd_pc_q;
  logic                       rd_we_q;
  logic [REG_ADDR_WIDTH-1:0]  rd_addr_q;
  logic [DATA_WIDTH-1:0]      rd_data_q;
  logic                       wr_en;
  logic                       rd_load;
  logic [PTR_W-1:0]           rd_load_ptr;
  logic [CNT_WIDTH-1:0]       post_clamped;

  logic [PC_WIDTH-1:0]        mem_pc   [DEPTH];
  logic                       mem_we   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0]  mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0]      mem_data [DEPTH];

  assign post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;
  assign rd_last      = rd_valid_q && (rd_idx_q == count_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_rem_d  = post_rem_q;
    post_cfg_d  = post_cfg_q;
    trig_pc_d   = trig_pc_q;
    triggered_d = triggered_q;
    rd_ptr_d    = rd_ptr_q;
    rd_idx_d    = rd_idx_q;
    rd_valid_d  = rd_valid_q;
    wr_en       = 1'b0;
    rd_load     = 1'b0;
    rd_load_ptr = rd_ptr_q;
    if (abort) begin
      state_d    = S_IDLE;
      count_d    = '0;
      rd_valid_d = 1'b0;
    end else if (arm) begin
      state_d     = S_ARMED;
      count_d     = '0;
      wr_ptr_d    = '0;
      triggered_d = 1'b0;
      trig_pc_d   = trigger_pc;
      post_cfg_d  = post_clamped;
      rd_valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          if (trace_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != FULL) count_d = count_q + 1'b1;
            if (state_q == S_ARMED) begin
              if (trace_pc == trig_pc_q) begin
                triggered_d = 1'b1;
                if (post_cfg_q == '0) begin
                  state_d = S_DONE;
                end else begin
                  state_d    = S_POST;
                  post_rem_d = post_cfg_q;
                end
              end
            end else begin
              post_rem_d = post_rem_q - 1'b1;
              if (post_rem_q == CNT_WIDTH'(1)) state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          // count == DEPTH wraps to offset 0, so the oldest entry sits at wr_ptr
          if (count_q != '0) begin
            rd_load     = 1'b1;
            rd_load_ptr = wr_ptr_q - count_q[PTR_W-1:0];
            rd_idx_d    = (PTR_W+1)'(1);
            state_d     = S_READOUT;
          end
        end
        S_READOUT: begin
          if (rd_valid_q && rd_ready) begin
            if (rd_last) begin
              state_d    = S_IDLE;
              rd_valid_d = 1'b0;
            end else begin
              rd_load     = 1'b1;
              rd_load_ptr = rd_ptr_q + 1'b1;
              rd_idx_d    = rd_idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    if (rd_load) begin
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_load_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_rem_q  <= '0;
      post_cfg_q  <= '0;
      trig_pc_q   <= '0;
      triggered_q <= 1'b0;
      rd_ptr_q    <= '0;
      rd_idx_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_pc_q     <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_rem_q  <= post_rem_d;
      post_cfg_q  <= post_cfg_d;
      trig_pc_q   <= trig_pc_d;
      triggered_q <= triggered_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_idx_q    <= rd_idx_d;
      rd_valid_q  <= rd_valid_d;
      if (rd_load) begin
        rd_pc_q   <= mem_pc[rd_load_ptr];
        rd_we_q   <= mem_we[rd_load_ptr];
        rd_addr_q <= mem_addr[rd_load_ptr];
        rd_data_q <= mem_data[rd_load_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr_q]   <= trace_pc;
      mem_we[wr_ptr_q]   <= trace_reg_we;
      mem_addr[wr_ptr_q] <= trace_reg_addr;
      mem_data[wr_ptr_q] <= trace_reg_data;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0] ts_q, ts_d, rd_ts_q;
  logic [CNT_WIDTH-1:0] mem_ts [DEPTH];

  // An entry is stamped with the counter value including its own cycle
  always_comb begin
    ts_d = ts_q;
    if (!abort && arm) ts_d = '0;
    else if (state_q == S_ARMED || state_q == S_POST) ts_d = ts_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q <= ts_d;
      if (rd_load) rd_ts_q <= mem_ts[rd_load_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_ts[wr_ptr_q] <= ts_d;
  end

  assign rd_timestamp = rd_ts_q;
`else
  assign rd_timestamp = '0;
`endif

  assign armed       = (state_q == S_ARMED) || (state_q == S_POST);
  assign done        = (state_q == S_DONE) || (state_q == S_READOUT);
  assign triggered   = triggered_q;
  assign rd_valid    = rd_valid_q;
  assign rd_pc       = rd_pc_q;
  assign rd_reg_we   = rd_we_q;
  assign rd_reg_addr = rd_addr_q;
  assign rd_reg_data = rd_data_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer (DEPTH=8)
module tb_cpu_trace_buffer;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic [9:0]  trace_pc = '0;
  logic        trace_reg_we = 1'b0;
  logic [3:0]  trace_reg_addr = '0;
  logic [15:0] trace_reg_data = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  trigger_pc = '0;
  logic [15:0] post_count = '0;
  logic        armed, triggered, done, rd_valid, rd_reg_we, rd_last;
  logic        rd_ready = 1'b1;
  logic [9:0]  rd_pc;
  logic [3:0]  rd_reg_addr;
  logic [15:0] rd_reg_data, rd_timestamp;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  pc;
    logic [15:0] data;
    logic        last;
    logic [15:0] ts;
    bit          ts_chk;
  } exp_t;
  exp_t sb[$];

  cpu_trace_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_reg_we(trace_reg_we),
    .trace_reg_addr(trace_reg_addr), .trace_reg_data(trace_reg_data),
    .arm(arm), .abort(abort), .trigger_pc(trigger_pc), .post_count(post_count),
    .armed(armed), .triggered(triggered), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_reg_we(rd_reg_we),
    .rd_reg_addr(rd_reg_addr), .rd_reg_data(rd_reg_data),
    .rd_timestamp(rd_timestamp), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pc, input bit last, input int ts, input bit ts_chk);
    exp_t e;
    e.pc = 10'(pc); e.data = 16'(pc * 3); e.last = last; e.ts = 16'(ts); e.ts_chk = ts_chk;
    sb.push_back(e);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) push(p, p == hi, 0, !TS_EN);
  endtask

  task automatic do_arm(input int tpc, input int pcnt);
    arm = 1'b1; trigger_pc = 10'(tpc); post_count = 16'(pcnt);
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input int pc);
    trace_valid = 1'b1; trace_pc = 10'(pc); trace_reg_we = 1'b1;
    trace_reg_addr = 4'(pc); trace_reg_data = 16'(pc * 3);
    tick();
    trace_valid = 1'b0;
  endtask

  // stall_pat: 0 = always ready, 1 = ready pattern 1,0,0,1
  task automatic wait_idle(input string name, input bit stall_pat);
    logic [3:0] pat;
    int i;
    pat = 4'b1001;
    i = 0;
    while (i < 200 && !(sb.size() == 0 && !done && !rd_valid)) begin
      rd_ready = stall_pat ? pat[3 - (i % 4)] : 1'b1;
      tick();
      i++;
    end
    rd_ready = 1'b1;
    check({name, " drained"}, 32'(sb.size()), 32'd0);
    check({name, " idle"}, {30'd0, done, rd_valid}, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (i < 50 && !rd_valid) begin
      tick();
      i++;
    end
    check({name, " readout start"}, 32'(rd_valid), 32'd1);
  endtask

  // Monitor: pops on each accepted entry, checks hold-stability while stalled
  logic        hold_v = 1'b0;
  logic [9:0]  hold_pc;
  logic [15:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    exp_t e;
    if (hold_v && rd_valid) begin
      check("stall pc stable", 32'(rd_pc), 32'(hold_pc));
      check("stall data stable", 32'(rd_reg_data), 32'(hold_data));
      check("stall last stable", 32'(rd_last), 32'(hold_last));
    end
    hold_v    = !rst && rd_valid && !rd_ready;
    hold_pc   = rd_pc;
    hold_data = rd_reg_data;
    hold_last = rd_last;
    if (!rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected entry pc", 32'(rd_pc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rd_pc", 32'(rd_pc), 32'(e.pc));
        check("rd_reg_data", 32'(rd_reg_data), 32'(e.data));
        check("rd_reg_addr", 32'(rd_reg_addr), 32'(e.pc[3:0]));
        check("rd_reg_we", 32'(rd_reg_we), 32'd1);
        check("rd_last", 32'(rd_last), 32'(e.last));
        if (e.ts_chk) check("rd_timestamp", 32'(rd_timestamp), 32'(e.ts));
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, " flags"}, {28'd0, armed, triggered, done, rd_valid}, 32'd0);
    check({name, " rd_last/we"}, {30'd0, rd_last, rd_reg_we}, 32'd0);
    check({name, " rd_pc"}, 32'(rd_pc), 32'd0);
    check({name, " rd_reg_addr"}, 32'(rd_reg_addr), 32'd0);
    check({name, " rd_reg_data"}, 32'(rd_reg_data), 32'd0);
    check({name, " rd_timestamp"}, 32'(rd_timestamp), 32'd0);
  endtask

  initial begin
    tick(); tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // basic trigger with post entries; retires after DONE are ignored
    push_range(1, 7);
    do_arm(5, 2);
    check("armed after arm", 32'(armed), 32'd1);
    for (int p = 1; p <= 7; p++) retire(p);
    check("t1 done", 32'(done), 32'd1);
    check("t1 triggered", 32'(triggered), 32'd1);
    retire(8); retire(9);
    wait_idle("t1", 1'b0);

    // wrap-around: oldest 8 of 24
    push_range(16, 23);
    do_arm(20, 3);
    for (int p = 0; p <= 23; p++) retire(p);
    wait_idle("t2", 1'b0);

    // post_count 0: only the trigger entry
    push_range(0, 0);
    do_arm(0, 0);
    retire(0);
    retire(1);
    wait_idle("t3a", 1'b0);

    // post_count 100 clamps to 7
    push_range(3, 10);
    do_arm(3, 100);
    for (int p = 0; p <= 12; p++) retire(p);
    wait_idle("t3b", 1'b0);

    // readout with stalls
    push_range(1, 7);
    do_arm(5, 2);
    for (int p = 1; p <= 7; p++) retire(p);
    wait_idle("t4", 1'b1);

    // abort in POST
    do_arm(5, 3);
    for (int p = 1; p <= 6; p++) retire(p);
    check("t5a armed before abort", 32'(armed), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5a after abort", {29'd0, armed, done, rd_valid}, 32'd0);
    for (int p = 7; p <= 10; p++) retire(p);
    check("t5a stays idle", {29'd0, armed, done, rd_valid}, 32'd0);

    // arm mid-READOUT, with coincident trace_valid not captured
    rd_ready = 1'b0;
    do_arm(2, 0);
    retire(1); retire(2);
    wait_valid("t5b");
    arm = 1'b1; trigger_pc = 10'd7; post_count = 16'd0;
    trace_valid = 1'b1; trace_pc = 10'd7; trace_reg_we = 1'b1;
    trace_reg_addr = 4'd7; trace_reg_data = 16'd21;
    tick();
    arm = 1'b0; trace_valid = 1'b0;
    check("t5b rearm", {29'd0, armed, done, rd_valid}, 32'b100);
    check("t5b triggered cleared", 32'(triggered), 32'd0);
    push(8, 1'b0, 0, !TS_EN);
    push(7, 1'b1, 0, !TS_EN);
    retire(8); retire(7);
    wait_idle("t5b", 1'b0);

    // rst during READOUT
    rd_ready = 1'b0;
    do_arm(1, 0);
    retire(1);
    wait_valid("t6");
    rst = 1'b1;
    tick();
    check_all_zero("t6 rst");
    rst = 1'b0;
    rd_ready = 1'b1;
    tick();

    // timestamps: retires 2 and 5 cycles after the arm cycle
    push(4, 1'b0, TS_EN ? 2 : 0, 1'b1);
    push(9, 1'b1, TS_EN ? 5 : 0, 1'b1);
    do_arm(9, 0);
    tick();
    retire(4);
    tick(); tick();
    retire(9);
    wait_idle("t7", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the cpu core: records one entry per retired instruction (pc plus register write-back) into a circular buffer.
- Freezes a configurable number of entries after a pc trigger.
- Streams captured entries oldest-first over a valid/ready port, giving hardware the same per-retire visibility the simulation state dump gives.
- Sits beside cpu; fed by its retire signals, drained by a debug/UART path.

Parameters:
- PC_WIDTH, 10, width of trace_pc / trigger_pc (instruction memory address width)
- DATA_WIDTH, 16, register write-back data width
- REG_ADDR_WIDTH, 4, register index width (16 regs, r0 never written)
- DEPTH, 64, buffer entries; power of two, >= 4
- CNT_WIDTH, 16, width of post-trigger count and timestamp

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trace_valid  in  1  one instruction retired this cycle
- trace_pc  in  PC_WIDTH  pc of retired instruction
- trace_reg_we  in  1  retired instruction wrote a register
- trace_reg_addr  in  REG_ADDR_WIDTH  destination register
- trace_reg_data  in  DATA_WIDTH  written value
- arm  in  1  pulse: clear buffer, start capture
- abort  in  1  pulse: return to IDLE, discard contents
- trigger_pc  in  PC_WIDTH  trigger address, sampled on arm
- post_count  in  CNT_WIDTH  entries stored after the trigger entry, sampled on arm
- armed  out  1  state is ARMED or POST
- triggered  out  1  trigger seen since last arm
- done  out  1  state is DONE or READOUT
- rd_valid  out  1  rd_* hold a valid entry
- rd_ready  in  1  consumer accepts entry
- rd_pc  out  PC_WIDTH
- rd_reg_we  out  1
- rd_reg_addr  out  REG_ADDR_WIDTH
- rd_reg_data  out  DATA_WIDTH
- rd_timestamp  out  CNT_WIDTH  see Optional Feature
- rd_last  out  1  current entry is the final one

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset: state IDLE; all outputs 0; wr_ptr, count, post_remaining cleared. Buffer contents need no reset.
- States: IDLE, ARMED, POST, DONE, READOUT.
- abort: highest priority after rst. From any state, next state is IDLE and count=0.
- arm: next priority. From any state, next state is ARMED, count=0, wr_ptr=0, triggered=0.
  - Samples trigger_pc and post_count. post_count is clamped to DEPTH-1.
  - A trace_valid in the same cycle as arm is not captured.
- ARMED/POST capture: each trace_valid writes {pc, reg_we, reg_addr, reg_data} at wr_ptr.
  - wr_ptr increments mod DEPTH; count saturates at DEPTH. Older entries are overwritten silently.
- ARMED: trace_valid with trace_pc==trigger_pc stores that entry (the trigger entry) and sets triggered.
  - Next state is DONE if clamped post_count==0; otherwise POST with post_remaining=post_count.
- POST: each captured entry decrements post_remaining. The capture that reaches 0 moves state to DONE on the next cycle.
- DONE: capture stops and trace_valid is ignored. rd_ptr=(wr_ptr-count) mod DEPTH.
  - Next cycle state is READOUT with the first entry registered.
  - If count==0, state stays DONE with rd_valid=0.
- READOUT: rd_valid=1 with registered entry data. rd_last=1 when the entry is the count-th.
  - rd_* hold stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready, the next entry appears the following cycle with no bubble (buffer read is pipelined one entry ahead).
  - Acceptance with rd_last=1 moves state to IDLE with rd_valid=0 the next cycle.
- arm or abort during READOUT: the current entry is dropped and rd_valid=0 the next cycle.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - A CNT_WIDTH cycle counter clears on arm and increments every cycle in ARMED/POST, wrapping on overflow.
  - Each entry stores the counter value at capture; rd_timestamp presents it.
- Undefined: no counter and no timestamp storage; rd_timestamp tied to 0.

Test Plan:
- DEPTH=8, arm with trigger_pc=5, post_count=2, retire pcs 1..9 (reg_we=1, addr=pc, data=pc*3) -> done after pc 7; readout pcs 1..7 in order, data 3..21, rd_last on pc 7.
- DEPTH=8, trigger_pc=20, post_count=3, retire pcs 0..23 -> wrap; readout 8 entries pcs 16..23, oldest first.
- post_count=0, trigger_pc=0, first retire pc 0 -> single entry read, rd_last=1; post_count=100 with DEPTH=8 -> clamped to 7, exactly 8 entries read.
- rd_ready toggled 1,0,0,1 during readout -> rd_* stable while stalled; no entry lost or duplicated; returns to IDLE after last.
- abort in POST, and arm in mid-READOUT -> IDLE/ARMED next cycle, rd_valid=0, count=0; trace_valid coincident with arm is not captured.
- rst asserted in READOUT -> all outputs 0 next cycle. With TRACE_TIMESTAMP_EN, retires at cycles 2 and 5 after arm -> rd_timestamp 2 then 5.
